// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM) owning the instruction/data bus handshakes.
// Optional bus timeout is compiled in when CPU_CTRL_TIMEOUT_EN is defined.
module cpu_ctrl_fsm #(
   parameter int INSTR_W     = 16,
   parameter int RF_ADDR_W   = 4,
   parameter int SHIFT_W     = 4,
   parameter int LD_ST_ADDR  = 10,
   parameter int LINK_ADDR   = 11,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 halt_i,
   input  logic [INSTR_W-1:0]   instr_i,
   output logic                 instr_stb_o,
   input  logic                 instr_ack_i,
   output logic                 data_stb_o,
   output logic                 data_we_o,
   input  logic                 data_ack_i,
   input  logic                 zero_i,
   output logic [INSTR_W-1:0]   ir_o,
   output logic                 pc_we_o,
   output logic [1:0]           pc_mux_o,
   output logic [1:0]           pc_direct_ch_o,
   output logic [2:0]           alu_control_o,
   output logic [SHIFT_W-1:0]   alu_shift_o,
   output logic                 alu_imm_o,
   output logic                 result_ch_o,
   output logic                 result_hl_o,
   output logic                 rf_we_o,
   output logic [1:0]           rf_datain_o,
   output logic                 rf_hl_o,
   output logic [RF_ADDR_W-1:0] write_addr_o,
   output logic [RF_ADDR_W-1:0] read_addr_o,
   output logic                 illegal_o,
   output logic                 bus_err_o
);

   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_BNE  = 4'b1000;
   localparam logic [3:0] OP_LD   = 4'b1001;
   localparam logic [3:0] OP_ST   = 4'b1010;
   localparam logic [3:0] OP_JMP  = 4'b1011;
   localparam logic [3:0] OP_NOP  = 4'b1100;

   typedef enum logic [1:0] {
      S_FETCH  = 2'b00,
      S_DECODE = 2'b01,
      S_EXEC   = 2'b10,
      S_MEM    = 2'b11
   } state_t;

   state_t               state_q, state_d;
   logic                 run_q;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic                 pend_q, pend_d;
   logic [2:0]           alu_control_q, alu_control_d;
   logic [SHIFT_W-1:0]   alu_shift_q, alu_shift_d;
   logic                 alu_imm_q, alu_imm_d;
   logic                 result_ch_q, result_ch_d;
   logic                 result_hl_q, result_hl_d;
   logic                 rf_hl_q, rf_hl_d;
   logic [1:0]           rf_datain_q, rf_datain_d;
   logic [1:0]           pc_direct_ch_q, pc_direct_ch_d;
   logic [1:0]           pc_mux_q, pc_mux_d;
   logic [RF_ADDR_W-1:0] write_addr_q, write_addr_d;
   logic [RF_ADDR_W-1:0] read_addr_q, read_addr_d;
   logic                 ex_rf_we_q, ex_rf_we_d;
   logic                 ex_pc_we_q, ex_pc_we_d;
   logic                 bne_q, bne_d;
   logic                 illegal_q, illegal_d;
   logic                 is_ld_q, is_ld_d;
   logic                 is_st_q, is_st_d;

   logic                 timeout;
   logic                 err_gate;
   logic                 err_pc;

   logic [3:0]           op;
   logic [1:0]           mtype;
   logic [RF_ADDR_W-1:0] f_wa;
   logic [RF_ADDR_W-1:0] f_ra;

   assign op    = ir_q[INSTR_W-1 -: 4];
   assign mtype = ir_q[INSTR_W-5 -: 2];
   assign f_wa  = ir_q[INSTR_W-5 -: RF_ADDR_W];
   assign f_ra  = ir_q[INSTR_W-5-RF_ADDR_W -: RF_ADDR_W];

`ifdef CPU_CTRL_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q;
   logic             err_mem_q;
   logic             bus_wait;

   assign bus_wait = (instr_stb_o && !instr_ack_i) || (data_stb_o && !data_ack_i);
   assign timeout  = bus_wait && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = '0;
      if (bus_wait && !timeout) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
         err_mem_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bus_err_q <= timeout;
         err_mem_q <= timeout && (state_q == S_MEM);
      end
   end

   // The error cycle keeps stb low; an abandoned MEM access still advances the PC.
   assign err_gate  = bus_err_q;
   assign err_pc    = bus_err_q && err_mem_q;
   assign bus_err_o = bus_err_q;
`else
   assign timeout   = 1'b0;
   assign err_gate  = 1'b0;
   assign err_pc    = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   // pend_q keeps a started fetch alive even if halt_i rises before the ack.
   assign instr_stb_o = (state_q == S_FETCH) && run_q && !err_gate && (!halt_i || pend_q);
   assign data_stb_o  = (state_q == S_MEM);
   assign data_we_o   = (state_q == S_MEM) && is_st_q;
   assign pc_we_o     = ((state_q == S_EXEC) && ex_pc_we_q) ||
                        ((state_q == S_MEM) && data_ack_i) || err_pc;
   assign pc_mux_o    = !pc_we_o ? 2'b00 :
                        ((state_q == S_EXEC) && bne_q) ? (zero_i ? 2'b01 : 2'b10) : pc_mux_q;
   assign rf_we_o     = ((state_q == S_EXEC) && ex_rf_we_q) ||
                        ((state_q == S_MEM) && is_ld_q && data_ack_i);
   assign illegal_o   = (state_q == S_EXEC) && illegal_q;

   assign ir_o           = ir_q;
   assign pc_direct_ch_o = pc_direct_ch_q;
   assign alu_control_o  = alu_control_q;
   assign alu_shift_o    = alu_shift_q;
   assign alu_imm_o      = alu_imm_q;
   assign result_ch_o    = result_ch_q;
   assign result_hl_o    = result_hl_q;
   assign rf_datain_o    = rf_datain_q;
   assign rf_hl_o        = rf_hl_q;
   assign write_addr_o   = write_addr_q;
   assign read_addr_o    = read_addr_q;

   always_comb begin
      state_d        = state_q;
      ir_d           = ir_q;
      pend_d         = pend_q;
      alu_control_d  = alu_control_q;
      alu_shift_d    = alu_shift_q;
      alu_imm_d      = alu_imm_q;
      result_ch_d    = result_ch_q;
      result_hl_d    = result_hl_q;
      rf_hl_d        = rf_hl_q;
      rf_datain_d    = rf_datain_q;
      pc_direct_ch_d = pc_direct_ch_q;
      pc_mux_d       = pc_mux_q;
      write_addr_d   = write_addr_q;
      read_addr_d    = read_addr_q;
      ex_rf_we_d     = ex_rf_we_q;
      ex_pc_we_d     = ex_pc_we_q;
      bne_d          = bne_q;
      illegal_d      = illegal_q;
      is_ld_d        = is_ld_q;
      is_st_d        = is_st_q;

      case (state_q)
         S_FETCH: begin
            if (timeout) begin
               pend_d = 1'b0;
            end else if (instr_stb_o) begin
               if (instr_ack_i) begin
                  ir_d    = instr_i;
                  pend_d  = 1'b0;
                  state_d = S_DECODE;
               end else begin
                  pend_d = 1'b1;
               end
            end
         end

         S_DECODE: begin
            state_d        = S_EXEC;
            alu_control_d  = 3'b000;
            alu_shift_d    = '0;
            alu_imm_d      = 1'b0;
            result_ch_d    = 1'b0;
            result_hl_d    = 1'b0;
            rf_hl_d        = 1'b0;
            rf_datain_d    = 2'b00;
            pc_direct_ch_d = 2'b00;
            pc_mux_d       = 2'b10;
            write_addr_d   = f_wa;
            read_addr_d    = f_ra;
            ex_rf_we_d     = 1'b0;
            ex_pc_we_d     = 1'b1;
            bne_d          = 1'b0;
            illegal_d      = 1'b0;
            is_ld_d        = 1'b0;
            is_st_d        = 1'b0;

            if (!op[3]) begin
               ex_rf_we_d  = 1'b1;
               rf_datain_d = 2'b01;
               alu_imm_d   = (op == OP_ADDI);
               case (op[2:0])
                  3'b000, 3'b001: alu_control_d = 3'b000;
                  3'b010:         alu_control_d = 3'b001;
                  3'b011:         alu_control_d = 3'b010;
                  3'b100:         alu_control_d = 3'b011;
                  3'b101:         alu_control_d = 3'b100;
                  3'b110: begin
                     alu_control_d = 3'b101;
                     alu_shift_d   = ir_q[SHIFT_W+3:4];
                  end
                  default: begin
                     alu_control_d = 3'b110;
                     alu_shift_d   = ir_q[SHIFT_W+3:4];
                  end
               endcase
            end else begin
               case (op)
                  OP_BNE: begin
                     alu_control_d  = 3'b111;
                     pc_direct_ch_d = 2'b01;
                     bne_d          = 1'b1;
                  end
                  OP_LD: begin
                     is_ld_d      = 1'b1;
                     ex_pc_we_d   = 1'b0;
                     write_addr_d = RF_ADDR_W'(LD_ST_ADDR);
                     rf_hl_d      = |mtype;
                  end
                  OP_ST: begin
                     is_st_d     = 1'b1;
                     ex_pc_we_d  = 1'b0;
                     result_ch_d = 1'b1;
                     read_addr_d = RF_ADDR_W'(LD_ST_ADDR);
                     result_hl_d = |mtype;
                  end
                  OP_JMP: begin
                     // mtype[1] picks register vs direct target, mtype[0] requests a link write.
                     pc_mux_d       = 2'b01;
                     pc_direct_ch_d = mtype[1] ? 2'b00 : 2'b01;
                     if (mtype[0]) begin
                        ex_rf_we_d   = 1'b1;
                        rf_datain_d  = 2'b10;
                        write_addr_d = RF_ADDR_W'(LINK_ADDR);
                     end
                  end
                  OP_NOP: begin
                     illegal_d = 1'b0;
                  end
                  default: begin
                     illegal_d = 1'b1;
                  end
               endcase
            end
         end

         S_EXEC: begin
            state_d = (is_ld_q || is_st_q) ? S_MEM : S_FETCH;
         end

         default: begin
            if (data_ack_i || timeout) begin
               state_d = S_FETCH;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_FETCH;
         run_q          <= 1'b0;
         ir_q           <= '0;
         pend_q         <= 1'b0;
         alu_control_q  <= 3'b000;
         alu_shift_q    <= '0;
         alu_imm_q      <= 1'b0;
         result_ch_q    <= 1'b0;
         result_hl_q    <= 1'b0;
         rf_hl_q        <= 1'b0;
         rf_datain_q    <= 2'b00;
         pc_direct_ch_q <= 2'b00;
         pc_mux_q       <= 2'b00;
         write_addr_q   <= '0;
         read_addr_q    <= '0;
         ex_rf_we_q     <= 1'b0;
         ex_pc_we_q     <= 1'b0;
         bne_q          <= 1'b0;
         illegal_q      <= 1'b0;
         is_ld_q        <= 1'b0;
         is_st_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         run_q          <= 1'b1;
         ir_q           <= ir_d;
         pend_q         <= pend_d;
         alu_control_q  <= alu_control_d;
         alu_shift_q    <= alu_shift_d;
         alu_imm_q      <= alu_imm_d;
         result_ch_q    <= result_ch_d;
         result_hl_q    <= result_hl_d;
         rf_hl_q        <= rf_hl_d;
         rf_datain_q    <= rf_datain_d;
         pc_direct_ch_q <= pc_direct_ch_d;
         pc_mux_q       <= pc_mux_d;
         write_addr_q   <= write_addr_d;
         read_addr_q    <= read_addr_d;
         ex_rf_we_q     <= ex_rf_we_d;
         ex_pc_we_q     <= ex_pc_we_d;
         bne_q          <= bne_d;
         illegal_q      <= illegal_d;
         is_ld_q        <= is_ld_d;
         is_st_q        <= is_st_d;
      end
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed testbench for cpu_ctrl_fsm: inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_cpu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        halt_i;
   logic [15:0] instr_i;
   logic        instr_stb_o;
   logic        instr_ack_i;
   logic        data_stb_o;
   logic        data_we_o;
   logic        data_ack_i;
   logic        zero_i;
   logic [15:0] ir_o;
   logic        pc_we_o;
   logic [1:0]  pc_mux_o;
   logic [1:0]  pc_direct_ch_o;
   logic [2:0]  alu_control_o;
   logic [3:0]  alu_shift_o;
   logic        alu_imm_o;
   logic        result_ch_o;
   logic        result_hl_o;
   logic        rf_we_o;
   logic [1:0]  rf_datain_o;
   logic        rf_hl_o;
   logic [3:0]  write_addr_o;
   logic [3:0]  read_addr_o;
   logic        illegal_o;
   logic        bus_err_o;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   cpu_ctrl_fsm dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .halt_i         (halt_i),
      .instr_i        (instr_i),
      .instr_stb_o    (instr_stb_o),
      .instr_ack_i    (instr_ack_i),
      .data_stb_o     (data_stb_o),
      .data_we_o      (data_we_o),
      .data_ack_i     (data_ack_i),
      .zero_i         (zero_i),
      .ir_o           (ir_o),
      .pc_we_o        (pc_we_o),
      .pc_mux_o       (pc_mux_o),
      .pc_direct_ch_o (pc_direct_ch_o),
      .alu_control_o  (alu_control_o),
      .alu_shift_o    (alu_shift_o),
      .alu_imm_o      (alu_imm_o),
      .result_ch_o    (result_ch_o),
      .result_hl_o    (result_hl_o),
      .rf_we_o        (rf_we_o),
      .rf_datain_o    (rf_datain_o),
      .rf_hl_o        (rf_hl_o),
      .write_addr_o   (write_addr_o),
      .read_addr_o    (read_addr_o),
      .illegal_o      (illegal_o),
      .bus_err_o      (bus_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Called just after a posedge; returns just after the posedge that enters DECODE.
   task automatic fetch_ok(input logic [15:0] ins);
      int n = 0;
      instr_i     = ins;
      instr_ack_i = 1'b1;
      @(negedge clk);
      while (instr_stb_o !== 1'b1 && n < 8) begin
         nxt();
         @(negedge clk);
         n++;
      end
      chk("fetch_stb", 32'(instr_stb_o), 32'd1);
      nxt();
      instr_ack_i = 1'b0;
      instr_i     = 16'h0000;
   endtask

   // Fetches ins and stops at the negedge of its EXEC cycle.
   task automatic exec_of(input logic [15:0] ins);
      fetch_ok(ins);
      @(negedge clk);
      nxt();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; halt_i = 1'b0; instr_i = 16'h0; instr_ack_i = 1'b0;
      data_ack_i = 1'b0; zero_i = 1'b0;

      @(negedge clk);
      chk("rst_instr_stb", 32'(instr_stb_o), 32'd0);
      chk("rst_data_stb",  32'(data_stb_o),  32'd0);
      chk("rst_data_we",   32'(data_we_o),   32'd0);
      chk("rst_pc_we",     32'(pc_we_o),     32'd0);
      chk("rst_pc_mux",    32'(pc_mux_o),    32'd0);
      chk("rst_rf_we",     32'(rf_we_o),     32'd0);
      chk("rst_ir",        32'(ir_o),        32'd0);
      chk("rst_illegal",   32'(illegal_o),   32'd0);
      chk("rst_bus_err",   32'(bus_err_o),   32'd0);
      nxt();
      rst_n = 1'b1;

      // ADD: strobes exactly in cycle 3
      fetch_ok(16'h0123);
      @(negedge clk);
      chk("add_dec_ir",    32'(ir_o),        32'h0123);
      chk("add_dec_rf_we", 32'(rf_we_o),     32'd0);
      chk("add_dec_pc_we", 32'(pc_we_o),     32'd0);
      chk("add_dec_stb",   32'(instr_stb_o), 32'd0);
      nxt();
      @(negedge clk);
      chk("add_rf_we",     32'(rf_we_o),       32'd1);
      chk("add_rf_datain", 32'(rf_datain_o),   32'd1);
      chk("add_alu_ctl",   32'(alu_control_o), 32'd0);
      chk("add_alu_imm",   32'(alu_imm_o),     32'd0);
      chk("add_pc_we",     32'(pc_we_o),       32'd1);
      chk("add_pc_mux",    32'(pc_mux_o),      32'd2);
      nxt();
      @(negedge clk);
      chk("add_back_stb",   32'(instr_stb_o), 32'd1);
      chk("add_back_rf_we", 32'(rf_we_o),     32'd0);
      chk("add_back_pc_we", 32'(pc_we_o),     32'd0);
      chk("add_back_pc_mux",32'(pc_mux_o),    32'd0);
      nxt();

      exec_of(16'h6050);
      chk("sll_shift", 32'(alu_shift_o),   32'd5);
      chk("sll_ctl",   32'(alu_control_o), 32'd5);
      chk("sll_rf_we", 32'(rf_we_o),       32'd1);
      nxt();

      exec_of(16'h70F0);
      chk("rot_shift", 32'(alu_shift_o),   32'hF);
      chk("rot_ctl",   32'(alu_control_o), 32'd6);
      nxt();

      exec_of(16'h1030);
      chk("addi_imm",   32'(alu_imm_o),     32'd1);
      chk("addi_ctl",   32'(alu_control_o), 32'd0);
      chk("addi_shift", 32'(alu_shift_o),   32'd0);
      nxt();

      zero_i = 1'b1;
      exec_of(16'h8000);
      chk("bne_z1_pc_mux", 32'(pc_mux_o),       32'd1);
      chk("bne_z1_direct", 32'(pc_direct_ch_o), 32'd1);
      chk("bne_z1_ctl",    32'(alu_control_o),  32'd7);
      chk("bne_z1_pc_we",  32'(pc_we_o),        32'd1);
      chk("bne_z1_rf_we",  32'(rf_we_o),        32'd0);
      nxt();
      zero_i = 1'b0;
      exec_of(16'h8000);
      chk("bne_z0_pc_mux", 32'(pc_mux_o), 32'd2);
      chk("bne_z0_rf_we",  32'(rf_we_o),  32'd0);
      nxt();

      // LD with three wait cycles before ack
      exec_of(16'h9400);
      chk("ld_exec_dstb",  32'(data_stb_o), 32'd0);
      chk("ld_exec_pc_we", 32'(pc_we_o),    32'd0);
      chk("ld_exec_rf_we", 32'(rf_we_o),    32'd0);
      for (int i = 0; i < 3; i++) begin
         nxt();
         @(negedge clk);
         chk("ld_wait_dstb",  32'(data_stb_o), 32'd1);
         chk("ld_wait_rf_we", 32'(rf_we_o),    32'd0);
         chk("ld_wait_pc_we", 32'(pc_we_o),    32'd0);
      end
      nxt();
      data_ack_i = 1'b1;
      @(negedge clk);
      chk("ld_ack_dstb",   32'(data_stb_o),   32'd1);
      chk("ld_ack_dwe",    32'(data_we_o),    32'd0);
      chk("ld_rf_we",      32'(rf_we_o),      32'd1);
      chk("ld_rf_hl",      32'(rf_hl_o),      32'd1);
      chk("ld_wr_addr",    32'(write_addr_o), 32'd10);
      chk("ld_rf_datain",  32'(rf_datain_o),  32'd0);
      chk("ld_pc_we",      32'(pc_we_o),      32'd1);
      chk("ld_pc_mux",     32'(pc_mux_o),     32'd2);
      nxt();
      data_ack_i = 1'b0;
      @(negedge clk);
      chk("ld_done_dstb", 32'(data_stb_o),  32'd0);
      chk("ld_done_istb", 32'(instr_stb_o), 32'd1);
      chk("ld_done_rf_we",32'(rf_we_o),     32'd0);
      nxt();

      // ST acked in its first MEM cycle
      exec_of(16'hA000);
      nxt();
      data_ack_i = 1'b1;
      @(negedge clk);
      chk("st_dstb",    32'(data_stb_o),  32'd1);
      chk("st_dwe",     32'(data_we_o),   32'd1);
      chk("st_res_hl",  32'(result_hl_o), 32'd0);
      chk("st_rd_addr", 32'(read_addr_o), 32'd10);
      chk("st_rf_we",   32'(rf_we_o),     32'd0);
      chk("st_pc_we",   32'(pc_we_o),     32'd1);
      chk("st_pc_mux",  32'(pc_mux_o),    32'd2);
      nxt();
      data_ack_i = 1'b0;

      exec_of(16'hB400);
      chk("jmpl_rf_we",   32'(rf_we_o),        32'd1);
      chk("jmpl_datain",  32'(rf_datain_o),    32'd2);
      chk("jmpl_wr_addr", 32'(write_addr_o),   32'd11);
      chk("jmpl_pc_mux",  32'(pc_mux_o),       32'd1);
      chk("jmpl_pc_we",   32'(pc_we_o),        32'd1);
      chk("jmpl_direct",  32'(pc_direct_ch_o), 32'd1);
      nxt();

      exec_of(16'hB800);
      chk("jmpr_direct", 32'(pc_direct_ch_o), 32'd0);
      chk("jmpr_rf_we",  32'(rf_we_o),        32'd0);
      chk("jmpr_pc_mux", 32'(pc_mux_o),       32'd1);
      nxt();

      exec_of(16'hE000);
      chk("ill_pulse",  32'(illegal_o), 32'd1);
      chk("ill_pc_we",  32'(pc_we_o),   32'd1);
      chk("ill_pc_mux", 32'(pc_mux_o),  32'd2);
      chk("ill_rf_we",  32'(rf_we_o),   32'd0);

      // halt blocks a fresh fetch, but not one already requested
      nxt();
      halt_i = 1'b1;
      @(negedge clk);
      chk("ill_end",     32'(illegal_o),   32'd0);
      chk("halt_stb",    32'(instr_stb_o), 32'd0);
      nxt();
      @(negedge clk);
      chk("halt_stb2",   32'(instr_stb_o), 32'd0);
      nxt();
      halt_i = 1'b0;
      @(negedge clk);
      chk("unhalt_stb",  32'(instr_stb_o), 32'd1);
      nxt();
      halt_i = 1'b1;
      @(negedge clk);
      chk("halt_pend_stb", 32'(instr_stb_o), 32'd1);
      nxt();
      halt_i = 1'b0;

      // reset while LD waits in MEM
      exec_of(16'h9000);
      nxt();
      @(negedge clk);
      chk("rstm_dstb_pre", 32'(data_stb_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstm_dstb",  32'(data_stb_o),  32'd0);
      chk("rstm_istb",  32'(instr_stb_o), 32'd0);
      chk("rstm_rf_we", 32'(rf_we_o),     32'd0);
      chk("rstm_pc_we", 32'(pc_we_o),     32'd0);
      data_ack_i = 1'b1;
      nxt();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstm_rel_rf_we", 32'(rf_we_o),    32'd0);
      chk("rstm_rel_dstb",  32'(data_stb_o), 32'd0);
      nxt();
      data_ack_i = 1'b0;
      @(negedge clk);
      chk("rstm_refetch", 32'(instr_stb_o), 32'd1);
      chk("rstm_rf_we2",  32'(rf_we_o),     32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle successor to the combinational CPU control decoder. Runs a FETCH/DECODE/EXEC/MEM state machine.
- Owns the instruction and data bus stb/ack handshakes and holds the instruction register.
- Emits registered datapath controls (ALU, RF, PC mux, memory). Parametrised in instruction, register-address and shift widths.
- Sits between the instruction/data bus and the CPU datapath (RF, ALU, PC).

Parameters:
INSTR_W, 16, instruction width; op = instr[INSTR_W-1 -: 4], mtype = instr[INSTR_W-5 -: 2]
RF_ADDR_W, 4, register-file address width
SHIFT_W, 4, shift-amount width; field = instr[SHIFT_W+3:4]
LD_ST_ADDR, 10, RF address holding the LD/ST pointer
LINK_ADDR, 11, RF address written by JMP link modes
TIMEOUT_CYC, 255, bus timeout in cycles (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
halt_i  in  1  hold in FETCH, no new fetch
instr_i  in  INSTR_W  instruction bus data
instr_stb_o  out  1  instruction request
instr_ack_i  in  1  instruction accept
data_stb_o  out  1  data request
data_we_o  out  1  data write (ST)
data_ack_i  in  1  data accept
zero_i  in  1  ALU zero flag
ir_o  out  INSTR_W  latched instruction
pc_we_o  out  1  PC update strobe
pc_mux_o  out  2  00 hold, 01 direct target, 10 PC+1
pc_direct_ch_o  out  2  direct target source
alu_control_o  out  3  ALU op
alu_shift_o  out  SHIFT_W  shift amount
alu_imm_o  out  1  ALU B = immediate (ADDI)
result_ch_o  out  1  result select
result_hl_o  out  1  ST high/low half
rf_we_o  out  1  RF write strobe
rf_datain_o  out  2  RF write source: 00 mem, 01 ALU, 10 PC link
rf_hl_o  out  1  LD high/low half
write_addr_o  out  RF_ADDR_W  RF write address
read_addr_o  out  RF_ADDR_W  RF read address
illegal_o  out  1  one-cycle pulse on undefined opcode
bus_err_o  out  1  one-cycle pulse on bus timeout (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0):
  - State FETCH; IR=0.
  - All strobes, pc_we_o, rf_we_o, data_we_o, illegal_o and bus_err_o = 0.
  - pc_mux_o=00; all other controls 0.
  - Reset mid-transaction drops stb immediately. No write completes.
- FETCH:
  - instr_stb_o=1 while halt_i=0.
  - When instr_ack_i=1 in a cycle with stb=1: IR<=instr_i, go to DECODE.
  - Ack with stb=0 is ignored. halt_i sampled only in FETCH; a transaction already started completes.
- DECODE: one cycle. Registers every control field from IR. Opcode encoding is unchanged:
  - ADD 0000, ADDI 0001, OR 0010, AND 0011, XOR 0100, NOR 0101, SLL 0110, ROT 0111
  - BNE 1000, LD 1001, ST 1010, JMP 1011, NOP 1100
- EXEC (one cycle):
  - ALU ops (0000-0111): rf_we_o=1, rf_datain_o=01; pc_we_o=1, pc_mux_o=10.
    - alu_control_o: ADD/ADDI 000, OR 001, AND 010, XOR 011, NOR 100, SLL 101, ROT 110.
    - alu_imm_o=1 only for ADDI.
    - alu_shift_o = shift field for SLL/ROT, else 0.
  - BNE: alu_control_o=111, pc_direct_ch_o=01, pc_we_o=1. pc_mux_o=01 if zero_i=1, else 10. No RF write.
  - LD/ST: go to MEM.
    - LD: write_addr_o=LD_ST_ADDR.
    - ST: read_addr_o=LD_ST_ADDR, result_hl_o=|mtype.
  - JMP (pc_mux_o=01, pc_we_o=1):
    - mtype 00: direct, pc_direct_ch_o=01.
    - mtype 01: direct + link, rf_we_o=1, rf_datain_o=10, write_addr_o=LINK_ADDR.
    - mtype 10: register target, pc_direct_ch_o=00.
    - mtype 11: register target + link.
  - NOP: pc_we_o=1, pc_mux_o=10.
  - 1101-1111: treated as NOP, illegal_o pulses 1 cycle.
  - Every path except LD/ST returns to FETCH.
- MEM:
  - data_stb_o=1 until data_ack_i. data_we_o=1 for ST.
  - LD on ack: rf_we_o=1, rf_datain_o=00, rf_hl_o=|mtype.
  - On ack (LD or ST): pc_we_o=1, pc_mux_o=10, return to FETCH.
  - Ack in the first stb cycle is accepted.
- Strobes:
  - rf_we_o and pc_we_o are single-cycle per instruction.
  - instr_stb_o and data_stb_o are never both 1.
- Minimum latency: ALU/BNE/JMP/NOP 3 cycles; LD/ST 4 cycles. Each bus wait cycle adds 1.

Optional Feature:
- Macro CPU_CTRL_TIMEOUT_EN.
- When defined, an 8+ bit counter runs while any stb is high without ack.
  - At TIMEOUT_CYC: drop stb, pulse bus_err_o, no RF write.
  - FETCH timeout: retry FETCH.
  - MEM timeout: pc_we_o=1, pc_mux_o=10, go to FETCH.
- When undefined: no counter, stb waits indefinitely, bus_err_o tied 0.

Test Plan:
- Reset release, instr_i=16'h0123 (ADD), ack same cycle as stb → rf_we_o=1 with rf_datain_o=01, alu_control_o=000, and pc_we_o/pc_mux_o=10 exactly on cycle 3; back in FETCH.
- SLL 16'h6050 → alu_shift_o=5, alu_control_o=101. ROT 16'h70F0 → alu_shift_o=15, alu_control_o=110.
- BNE with zero_i=1 → pc_mux_o=01, pc_direct_ch_o=01. With zero_i=0 → pc_mux_o=10. rf_we_o=0 in both.
- LD 16'h9400 with data_ack_i delayed 3 cycles → data_stb_o high 4 cycles, then rf_we_o=1, rf_hl_o=1, write_addr_o=10. ST 16'hA000 → data_we_o=1, result_hl_o=0, no RF write.
- JMP 16'hB400 → rf_we_o=1, rf_datain_o=10, write_addr_o=11, pc_mux_o=01. Opcode 16'hE000 → illegal_o one pulse, PC+1.
- rst_n low during MEM wait → stbs drop same cycle, no rf_we_o. With CPU_CTRL_TIMEOUT_EN and no ack → bus_err_o pulses after 255 cycles.
